// File: rtl/data_mem_pipe_pkg.sv
// Shared types and default sizing for the data_mem_pipe block.
package data_mem_pipe_pkg;

  // Controller state: CLEAR zeroes the memory, IDLE serves requests.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 32;

endpackage

// File: rtl/data_mem_pipe_mem_bank.sv
// Single-port synchronous RAM with byte-lane write enables and a registered
// read port.
module mem_bank
  import data_mem_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes; only lanes with their enable set are touched.
  // NOTE: the array has no reset branch so it maps onto RAM macros; the
  // controller's clear sequence is what gives it defined contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < NB; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Registered read; the output holds its value between reads.
  // NOTE: clocked state always uses non-blocking assignment so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Request/response front end for mem_bank: after reset it zeroes every word,
// then accepts one read or write per cycle with a one-cycle response.
module data_mem_pipe
  import data_mem_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic                last_clr;
  logic                in_range;
  logic                accept;
  logic                rsp_rd_q;

  logic                mem_we;
  logic                mem_re;
  logic [NB-1:0]       mem_be;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  // A fully populated address space cannot be out of range.
  if (DEPTH >= (1 << ADDR_W)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = (req_addr < ADDR_W'(DEPTH));
  end

  assign last_clr  = (clr_ptr_q == LAST_ADDR);
  assign req_ready = (state_q == IDLE) && !rst;
  assign busy      = !req_ready;
  assign accept    = req_valid && req_ready;

  // Next state and memory port steering: clear writes in CLEAR, requests in IDLE.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_be    = '0;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_be    = '1;
        mem_addr  = clr_ptr_q;
        mem_wdata = '0;
        if (last_clr) state_d = IDLE;
      end
      IDLE: begin
        mem_we = accept && req_wr && in_range;
        mem_re = accept && !req_wr && in_range;
        mem_be = req_be;
      end
      default: state_d = CLEAR;
    endcase
  end

  // State register and clear pointer; reset restarts clearing at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_ptr_q <= last_clr ? '0 : clr_ptr_q + 1'b1;
    end
  end

  // Response register: one pulse per accepted request, error flag for
  // out-of-range addresses, and a flag selecting read data onto the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rd_q  <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && !in_range;
      rsp_rd_q  <= accept && !req_wr && in_range;
    end
  end

  // Write and errored responses carry zero data.
  assign rsp_rdata = rsp_rd_q ? mem_rdata : '0;

  mem_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem_bank (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: a DEPTH=32 instance and a DEPTH=24
// instance share stimulus; sel24 routes req_valid to one of them.
module tb_data_mem_pipe;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        sel24;
  logic        req_wr;
  logic [4:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;

  logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_err_a, busy_a;
  logic [15:0] rsp_rdata_a;
  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_err_b, busy_b;
  logic [15:0] rsp_rdata_b;

  int checks;
  int errors;
  int n32, n24, stray;

  assign req_valid_a = req_valid && !sel24;
  assign req_valid_b = req_valid && sel24;

  data_mem_pipe #(.DATA_W(16), .ADDR_W(5), .DEPTH(32)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid_a),
    .req_ready (req_ready_a),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid_a),
    .rsp_rdata (rsp_rdata_a),
    .rsp_err   (rsp_err_a),
    .busy      (busy_a)
  );

  data_mem_pipe #(.DATA_W(16), .ADDR_W(5), .DEPTH(24)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid_b),
    .req_ready (req_ready_b),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid_b),
    .rsp_rdata (rsp_rdata_b),
    .rsp_err   (rsp_err_b),
    .busy      (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request at a negedge; returns at the negedge after acceptance,
  // when its response is visible.
  task automatic issue(input logic wr, input logic [4:0] addr,
                       input logic [15:0] wd, input logic [1:0] be);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_rsp(input string tag, input logic [15:0] exp_data, input logic exp_err);
    if (sel24) begin
      check({tag, "_valid"}, 32'(rsp_valid_b), 32'd1);
      check({tag, "_data"},  32'(rsp_rdata_b), 32'(exp_data));
      check({tag, "_err"},   32'(rsp_err_b),   32'(exp_err));
    end else begin
      check({tag, "_valid"}, 32'(rsp_valid_a), 32'd1);
      check({tag, "_data"},  32'(rsp_rdata_a), 32'(exp_data));
      check({tag, "_err"},   32'(rsp_err_a),   32'(exp_err));
    end
  endtask

  // One-cycle reset pulse with whatever request inputs are currently driven.
  task automatic pulse_rst(input string tag);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_busy"},  32'(busy_a),      32'd1);
    check({tag, "_ready"}, 32'(req_ready_a), 32'd0);
    check({tag, "_valid"}, 32'(rsp_valid_a), 32'd0);
    rst = 1'b0;
    #1;
  endtask

  // Count busy cycles after reset release, bounded.
  task automatic wait_ready();
    n32 = 0;
    n24 = 0;
    stray = 0;
    while (busy_a && n32 < 200) begin
      n32++;
      if (busy_b) n24++;
      if (rsp_valid_a) stray++;
      @(negedge clk);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    sel24     = 1'b0;
    // A write held during the whole clear sequence must never be accepted.
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 5'd2;
    req_wdata = 16'h5555;
    req_be    = 2'b11;
    @(negedge clk);

    pulse_rst("rst0");
    wait_ready();
    req_valid = 1'b0;
    check("clear_cycles_32", 32'(n32), 32'd32);
    check("clear_cycles_24", 32'(n24), 32'd24);
    check("clear_no_rsp", 32'(stray), 32'd0);
    check("ready_after_clear", 32'(req_ready_a), 32'd1);

    // Cleared contents, including the word targeted during CLEAR.
    issue(1'b0, 5'd0, 16'h0, 2'b00);  chk_rsp("rd0", 16'h0000, 1'b0);
    issue(1'b0, 5'd1, 16'h0, 2'b00);  chk_rsp("rd1", 16'h0000, 1'b0);
    issue(1'b0, 5'd31, 16'h0, 2'b00); chk_rsp("rd31", 16'h0000, 1'b0);
    issue(1'b0, 5'd2, 16'h0, 2'b00);  chk_rsp("rd2_after_clear", 16'h0000, 1'b0);
    idle();
    check("rsp_pulse_drop", 32'(rsp_valid_a), 32'd0);

    // Byte-lane merge.
    issue(1'b1, 5'd3, 16'hABCD, 2'b11); chk_rsp("wr3_full", 16'h0000, 1'b0);
    issue(1'b1, 5'd3, 16'h1234, 2'b01); chk_rsp("wr3_low", 16'h0000, 1'b0);
    issue(1'b0, 5'd3, 16'h0, 2'b00);    chk_rsp("rd3_merge", 16'hAB34, 1'b0);
    issue(1'b1, 5'd3, 16'hFFFF, 2'b00); chk_rsp("wr3_be0", 16'h0000, 1'b0);
    issue(1'b0, 5'd3, 16'h0, 2'b00);    chk_rsp("rd3_be0", 16'hAB34, 1'b0);

    // Back-to-back with read-after-write.
    issue(1'b1, 5'd0, 16'h0003, 2'b11); chk_rsp("b2b_wr0", 16'h0000, 1'b0);
    issue(1'b0, 5'd0, 16'h0, 2'b00);    chk_rsp("b2b_rd0", 16'h0003, 1'b0);
    issue(1'b0, 5'd1, 16'h0, 2'b00);    chk_rsp("b2b_rd1", 16'h0000, 1'b0);
    issue(1'b1, 5'd31, 16'h7788, 2'b10); chk_rsp("wr31_high", 16'h0000, 1'b0);
    issue(1'b0, 5'd31, 16'h0, 2'b00);    chk_rsp("rd31_high", 16'h7700, 1'b0);
    idle();

    // Reset with a read pending: no response; then reset again mid-clear.
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 5'd3;
    pulse_rst("rst1");
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("midclear_busy", 32'(busy_a), 32'd1);
    check("midclear_ready", 32'(req_ready_a), 32'd0);
    pulse_rst("rst2");
    wait_ready();
    check("restart_cycles_32", 32'(n32), 32'd32);
    check("restart_no_rsp", 32'(stray), 32'd0);
    issue(1'b0, 5'd3, 16'h0, 2'b00);  chk_rsp("rd3_recleared", 16'h0000, 1'b0);
    issue(1'b0, 5'd31, 16'h0, 2'b00); chk_rsp("rd31_recleared", 16'h0000, 1'b0);
    issue(1'b0, 5'd0, 16'h0, 2'b00);  chk_rsp("rd0_recleared", 16'h0000, 1'b0);
    idle();

    // Out-of-range handling on the DEPTH=24 instance.
    sel24 = 1'b1;
    issue(1'b1, 5'd25, 16'hFFFF, 2'b11); chk_rsp("d24_wr25", 16'h0000, 1'b1);
    issue(1'b0, 5'd25, 16'h0, 2'b00);    chk_rsp("d24_rd25", 16'h0000, 1'b1);
    issue(1'b0, 5'd23, 16'h0, 2'b00);    chk_rsp("d24_rd23", 16'h0000, 1'b0);
    issue(1'b1, 5'd23, 16'h1357, 2'b11); chk_rsp("d24_wr23", 16'h0000, 1'b0);
    issue(1'b0, 5'd23, 16'h0, 2'b00);    chk_rsp("d24_rd23_new", 16'h1357, 1'b0);
    idle();
    check("d24_err_clear", 32'(rsp_err_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_pipe.md
DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 5, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 32, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL have one clock and a synchronous, active-high reset: ports clk and rst.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  1  request present this cycle.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_wr  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  word address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 req_be  input  DATA_W/8  byte-lane write enables; bit k covers bits [8k+7:8k].
REQ-013 rsp_valid  output  1  response valid; one-cycle pulse per accepted request.
REQ-014 rsp_rdata  output  DATA_W  read data; 0 for writes and errored requests.
REQ-015 rsp_err  output  1  accepted request addressed a word >= DEPTH.
REQ-016 busy  output  1  clear sequence in progress.

Function
REQ-017 SHALL implement a two-state FSM, CLEAR and IDLE.
- CLEAR: one word zeroed per cycle at clr_ptr = 0..DEPTH-1.
- Final word written: transition to IDLE on the next edge.
REQ-018 In CLEAR, SHALL drive busy=1 and req_ready=0; request inputs are ignored.
REQ-019 In IDLE, SHALL drive busy=0 and req_ready=1.
REQ-020 A request SHALL be accepted on an edge where req_valid && req_ready.
REQ-021 Accepted in-range write SHALL update only the byte lanes whose req_be bit is 1; all other lanes keep their value.
REQ-022 Accepted write with req_be = 0 SHALL leave memory unchanged and still produce a response.
REQ-023 Accepted read SHALL return the word on rsp_rdata with rsp_valid=1 exactly one cycle after acceptance (registered read, latency 1).
REQ-024 Read-after-write: a read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-025 Back-to-back requests SHALL be accepted every cycle in IDLE; each produces its own response one cycle later, in order.
REQ-026 No response backpressure: rsp_valid SHALL be a single-cycle pulse that the consumer must capture.
REQ-027 Out-of-range address (req_addr >= DEPTH) SHALL:
- suppress the write;
- return rsp_rdata=0 and rsp_err=1 with rsp_valid=1, latency 1.
REQ-028 rsp_err SHALL be 0 whenever rsp_valid is 0 or the request was in range.
REQ-029 With DEPTH = 2**ADDR_W, rsp_err SHALL never assert.
REQ-030 Write responses SHALL carry rsp_rdata=0.

Reset
REQ-031 rst=1 SHALL, on the edge:
- enter CLEAR with clr_ptr=0;
- set rsp_valid=0, rsp_rdata=0, rsp_err=0;
- drop any pending response.
REQ-032 While rst=1, outputs SHALL be busy=1, req_ready=0, rsp_valid=0.
REQ-033 rst asserted mid-CLEAR SHALL restart clearing from address 0.
REQ-034 After rst deasserts, busy SHALL stay 1 for exactly DEPTH cycles, then req_ready=1.
REQ-035 No initial blocks SHALL be relied on for memory contents; the clear sequence defines them.

Structure
REQ-036 A shared package SHALL hold:
- the FSM state enum (CLEAR, IDLE);
- default constants DATA_W=16, ADDR_W=5, DEPTH=32.
REQ-037 SHALL use one sub-module, mem_bank: single-port synchronous RAM with byte-lane write enables and a registered read, DATA_W x DEPTH.
REQ-038 The FSM, clear pointer, range check and response register SHALL reside in data_mem_pipe.

Verification
REQ-039 Reset, then count cycles: busy=1 for 32 cycles, then req_ready=1; reads of addresses 0, 1, 31 return 0x0000.
REQ-040 Write 0xABCD to addr 3 with be=11, then write 0x1234 with be=01, then read addr 3 -> rsp_rdata=0xAB34, rsp_valid 1 cycle after read acceptance.
REQ-041 Back-to-back: write 0x0003 @0, read @0, read @1 on consecutive cycles -> responses in order: write rdata 0, then 0x0003, then 0x0000.
REQ-042 With DEPTH=24: write 0xFFFF @25 -> rsp_err=1; read @25 -> rsp_rdata=0, rsp_err=1; read @23 -> rsp_err=0.
REQ-043 Pulse rst at clear cycle 10 -> busy held, clear restarts at 0, busy deasserts 32 cycles after rst release; pending rsp_valid suppressed.
REQ-044 Requests driven during CLEAR (req_valid=1, write 0x5555 @2) -> not accepted, no response, addr 2 reads 0 after clear.
